ppm_frame_scheduler: RTL and testbench

- Multi-channel PPM frame generator and controller for the servo/RC signal path.
- Sequences NUM_CH channel pulse widths into one PPM pulse train: a fixed-width mark per channel, separated by programmable spaces, then a sync gap.
- Channel widths are written through a simple config port into shadow registers, which are committed atomically at each frame start.
- Sits upstream of the PWM/PPM conversion logic and drives the PPMSIG line plus frame and slot status.

---
 rtl/ppm_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_ppm_frame_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_frame_scheduler.sv
// ppm_frame_scheduler
//   Builds one PPM pulse train from NUM_CH channel slot widths. Each frame is
//   a fixed MARK_TICKS-long mark per channel, then a space that stretches the
//   slot to its programmed width. A closing end mark follows, and the sync gap
//   pads the frame to FRAME_TICKS, never shorter than MIN_SYNC.
//   Widths land in shadow registers and are committed to the active set only
//   on the cycle that starts a frame, so a frame never sees a partial update.
// Ports:
//   ClkFast      in   system clock, all timing in ClkFast cycles
//   Reset        in   asynchronous active-high reset
//   Enable       in   run request (level); a running frame always completes
//   CfgWr        in   shadow width write strobe
//   CfgAddr      in   channel index to write (>= NUM_CH ignored)
//   CfgData      in   channel slot width (mark + space) in cycles
//   PPMSIG       out  PPM output
//   FrameStart   out  one-cycle pulse on the first mark cycle of a frame
//   ChIndex      out  active channel slot, 0 when idle
//   Busy         out  high whenever the scheduler is not idle
//   FrameOverrun out  one-cycle pulse when the sync gap is forced to MIN_SYNC
module ppm_frame_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int MARK_TICKS  = 20,
    parameter int FRAME_TICKS = 1000,
    parameter int MIN_SYNC    = 100
) (
    input  logic             ClkFast,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             CfgWr,
    input  logic [2:0]       CfgAddr,
    input  logic [CNT_W-1:0] CfgData,
    output logic             PPMSIG,
    output logic             FrameStart,
    output logic [2:0]       ChIndex,
    output logic             Busy,
    output logic             FrameOverrun
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FC_W = CNT_W + 4;

    localparam logic [CNT_W-1:0] MARK_L     = CNT_W'(MARK_TICKS);
    localparam logic [CNT_W-1:0] MARK_LAST  = CNT_W'(MARK_TICKS - 1);
    localparam logic [CNT_W-1:0] SLOT_MIN   = CNT_W'(MARK_TICKS + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(MIN_SYNC - 1);
    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAME_TICKS - 1);
    localparam logic [FC_W-1:0]  OVR_LIMIT  = FC_W'(FRAME_TICKS - MIN_SYNC);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MARK     = 3'd1,
        S_SPACE    = 3'd2,
        S_END_MARK = 3'd3,
        S_SYNC     = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FC_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0] r_shadow [NUM_CH];
    logic [CNT_W-1:0] r_active [NUM_CH];
    logic             r_ppm;
    logic             r_fs;
    logic [2:0]       r_ch;
    logic             r_busy;
    logic             r_ovr;

    state_t           w_state_nxt;
    logic             w_start;
    logic [CNT_W-1:0] w_width;
    logic [CNT_W-1:0] w_slot;
    logic [CNT_W-1:0] w_space_last;
    logic             w_mark_done;
    logic             w_space_done;
    logic             w_sync_done;
    logic             w_overrun;
    logic             w_ppm_nxt;
    logic             w_fs_nxt;
    logic [2:0]       w_ch_nxt;
    logic             w_busy_nxt;
    logic             w_ovr_nxt;

    // Slot is clamped so every space lasts at least one cycle.
    assign w_width      = r_active[r_ch[CH_W-1:0]];
    assign w_slot       = (w_width > MARK_L) ? w_width : SLOT_MIN;
    assign w_space_last = w_slot - MARK_L - CNT_W'(1'b1);
    assign w_mark_done  = (r_cnt == MARK_LAST);
    assign w_space_done = (r_cnt == w_space_last);
    // Sync ends once the frame has reached FRAME_TICKS and MIN_SYNC has elapsed,
    // which yields max(FRAME_TICKS - elapsed, MIN_SYNC) cycles.
    assign w_sync_done  = (r_frame_cnt >= FRAME_LAST) && (r_cnt >= SYNC_LAST);
    // Evaluated on the last end-mark cycle: elapsed at sync entry is r_frame_cnt + 1.
    assign w_overrun    = (r_frame_cnt >= OVR_LIMIT);

    // State register.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and frame-start detection.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable) begin
                    w_state_nxt = S_MARK;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MARK: begin
                if (w_mark_done) begin
                    w_state_nxt = S_SPACE;
                end else begin
                    w_state_nxt = S_MARK;
                end
            end
            S_SPACE: begin
                if (w_space_done && (r_ch < LAST_CH)) begin
                    w_state_nxt = S_MARK;
                end else if (w_space_done) begin
                    w_state_nxt = S_END_MARK;
                end else begin
                    w_state_nxt = S_SPACE;
                end
            end
            S_END_MARK: begin
                if (w_mark_done) begin
                    w_state_nxt = S_SYNC;
                end else begin
                    w_state_nxt = S_END_MARK;
                end
            end
            S_SYNC: begin
                if (w_sync_done && Enable) begin
                    w_state_nxt = S_MARK;
                    w_start     = 1'b1;
                end else if (w_sync_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SYNC;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it.
    always_comb begin
        w_ppm_nxt  = (w_state_nxt == S_MARK) || (w_state_nxt == S_END_MARK);
        w_fs_nxt   = w_start;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_ovr_nxt  = (r_state == S_END_MARK) && (w_state_nxt == S_SYNC) && w_overrun;
        if (w_start || (w_state_nxt == S_IDLE)) begin
            w_ch_nxt = 3'd0;
        end else if ((r_state == S_SPACE) && (w_state_nxt == S_MARK)) begin
            w_ch_nxt = r_ch + 3'd1;
        end else begin
            w_ch_nxt = r_ch;
        end
    end

    // Registered outputs.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            r_ppm  <= 1'b0;
            r_fs   <= 1'b0;
            r_ch   <= 3'd0;
            r_busy <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ppm  <= w_ppm_nxt;
            r_fs   <= w_fs_nxt;
            r_ch   <= w_ch_nxt;
            r_busy <= w_busy_nxt;
            r_ovr  <= w_ovr_nxt;
        end
    end

    // Per-state cycle counter; saturates in sync since only MIN_SYNC matters there.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == S_SYNC) && (r_cnt >= SYNC_LAST)) begin
            r_cnt <= r_cnt;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end
    end

    // Cycles since frame start; saturating so a huge frame cannot wrap.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            r_frame_cnt <= {FC_W{1'b0}};
        end else if (w_start) begin
            r_frame_cnt <= {FC_W{1'b0}};
        end else if ((r_state != S_IDLE) && (r_frame_cnt != {FC_W{1'b1}})) begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1'b1);
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    // Shadow width registers, writable in any state.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= {CNT_W{1'b0}};
            end
        end else if (CfgWr && (CfgAddr <= LAST_CH)) begin
            r_shadow[CfgAddr[CH_W-1:0]] <= CfgData;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // Active widths: atomic commit on frame start; a same-cycle write misses it.
    always_ff @(posedge ClkFast or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_active[i] <= {CNT_W{1'b0}};
            end
        end else if (w_start) begin
            r_active <= r_shadow;
        end else begin
            r_active <= r_active;
        end
    end

    assign PPMSIG       = r_ppm;
    assign FrameStart   = r_fs;
    assign ChIndex      = r_ch;
    assign Busy         = r_busy;
    assign FrameOverrun = r_ovr;

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
module tb_ppm_frame_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int MT  = 2;
    localparam int FT  = 40;
    localparam int MS  = 4;

    logic          ClkFast = 1'b0;
    logic          Reset   = 1'b1;
    logic          Enable  = 1'b0;
    logic          CfgWr   = 1'b0;
    logic [2:0]    CfgAddr = 3'd0;
    logic [CW-1:0] CfgData = 16'd0;
    logic          PPMSIG;
    logic          FrameStart;
    logic [2:0]    ChIndex;
    logic          Busy;
    logic          FrameOverrun;

    int total = 0;
    int bad   = 0;

    logic       cap_ppm  [256];
    logic       cap_fs   [256];
    logic       cap_ovr  [256];
    logic       cap_busy [256];
    logic [2:0] cap_ch   [256];
    logic       exp_ppm  [256];
    logic       exp_fs   [256];
    logic       exp_ovr  [256];
    logic [2:0] exp_ch   [256];

    ppm_frame_scheduler #(
        .NUM_CH(NCH), .CNT_W(CW), .MARK_TICKS(MT), .FRAME_TICKS(FT), .MIN_SYNC(MS)
    ) dut (
        .ClkFast(ClkFast), .Reset(Reset), .Enable(Enable), .CfgWr(CfgWr),
        .CfgAddr(CfgAddr), .CfgData(CfgData), .PPMSIG(PPMSIG),
        .FrameStart(FrameStart), .ChIndex(ChIndex), .Busy(Busy),
        .FrameOverrun(FrameOverrun)
    );

    always #5 ClkFast = ~ClkFast;

    task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] d);
        CfgWr = 1'b1; CfgAddr = a; CfgData = d;
        @(negedge ClkFast);
        CfgWr = 1'b0;
    endtask

    // Capture n samples; sample 0 is the current negedge.
    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge ClkFast);
            cap_ppm[i] = PPMSIG; cap_fs[i] = FrameStart; cap_ovr[i] = FrameOverrun;
            cap_busy[i] = Busy;  cap_ch[i] = ChIndex;
        end
    endtask

    // Reference waveform of one frame starting at index base.
    task automatic build_frame(input int w0, input int w1, input int w2, input int w3,
                               input int base, output int nxt);
        int w[4];
        int idx, sl, el, sy;
        w = '{w0, w1, w2, w3};
        idx = base;
        for (int c = 0; c < NCH; c++) begin
            sl = (w[c] < MT + 1) ? MT + 1 : w[c];
            for (int k = 0; k < sl; k++) begin
                exp_ppm[idx] = (k < MT); exp_ch[idx] = 3'(c);
                exp_fs[idx] = 1'b0; exp_ovr[idx] = 1'b0; idx++;
            end
        end
        for (int k = 0; k < MT; k++) begin
            exp_ppm[idx] = 1'b1; exp_ch[idx] = 3'(NCH - 1);
            exp_fs[idx] = 1'b0; exp_ovr[idx] = 1'b0; idx++;
        end
        el = idx - base;
        sy = (FT - el < MS) ? MS : FT - el;
        for (int k = 0; k < sy; k++) begin
            exp_ppm[idx] = 1'b0; exp_ch[idx] = 3'(NCH - 1);
            exp_fs[idx] = 1'b0; exp_ovr[idx] = (k == 0) && (FT - el < MS); idx++;
        end
        exp_fs[base] = 1'b1;
        nxt = idx;
    endtask

    task automatic go_idle();
        int n;
        Enable = 1'b0;
        n = 0;
        while (Busy !== 1'b0 && n < 200) begin
            @(negedge ClkFast);
            n++;
        end
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL go_idle timeout: Busy=%b required 0 within 200 cycles", Busy);
        end
    endtask

    task automatic test_reset();
        @(negedge ClkFast);
        total++;
        if ({PPMSIG, FrameStart, ChIndex, Busy, FrameOverrun} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got ppm/fs/ch/busy/ovr=%b/%b/%0d/%b/%b required all 0",
                     PPMSIG, FrameStart, ChIndex, Busy, FrameOverrun);
        end
        Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ClkFast);
            total++;
            if ({PPMSIG, FrameStart, ChIndex, Busy} !== 6'b0) begin
                bad++;
                $display("FAIL idle cyc=%0d: got ppm/fs/ch/busy=%b/%b/%0d/%b required 0/0/0/0",
                         i, PPMSIG, FrameStart, ChIndex, Busy);
            end
        end
    endtask

    task automatic test_nominal();
        int l1, l2, novr;
        cfg_write(3'd0, 16'd5);
        cfg_write(3'd4, 16'd30);
        cfg_write(3'd1, 16'd6);
        cfg_write(3'd2, 16'd7);
        cfg_write(3'd7, 16'd1);
        cfg_write(3'd3, 16'd8);
        Enable = 1'b1;
        @(negedge ClkFast);
        total++;
        if ({PPMSIG, FrameStart, Busy} !== 3'b111) begin
            bad++;
            $display("FAIL start_latency: got ppm/fs/busy=%b/%b/%b required 1/1/1",
                     PPMSIG, FrameStart, Busy);
        end
        record(81);
        build_frame(5, 6, 7, 8, 0, l1);
        build_frame(5, 6, 7, 8, l1, l2);
        for (int i = 0; i < 80; i++) begin
            total++;
            if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !==
                {exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i], 1'b1}) begin
                bad++;
                $display("FAIL nominal cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/1",
                         i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i],
                         exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i]);
            end
        end
        novr = 0;
        for (int i = 0; i < 80; i++) novr += int'(cap_ovr[i]);
        total++;
        if (cap_fs[40] !== 1'b1 || cap_fs[80] !== 1'b1 || novr != 0) begin
            bad++;
            $display("FAIL nominal_period: got fs@40=%b fs@80=%b overruns=%0d required 1 1 0",
                     cap_fs[40], cap_fs[80], novr);
        end
        go_idle();
    endtask

    task automatic test_overrun();
        int l1, l2, novr;
        for (int c = 0; c < NCH; c++) cfg_write(3'(c), 16'd10);
        Enable = 1'b1;
        @(negedge ClkFast);
        record(93);
        build_frame(10, 10, 10, 10, 0, l1);
        build_frame(10, 10, 10, 10, l1, l2);
        for (int i = 0; i < 92; i++) begin
            total++;
            if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !==
                {exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i], 1'b1}) begin
                bad++;
                $display("FAIL overrun cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/1",
                         i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i],
                         exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i]);
            end
        end
        novr = 0;
        for (int i = 0; i < 92; i++) novr += int'(cap_ovr[i]);
        total++;
        if (cap_fs[46] !== 1'b1 || cap_fs[92] !== 1'b1 || cap_ovr[42] !== 1'b1 || novr != 2) begin
            bad++;
            $display("FAIL overrun_period: got fs@46=%b fs@92=%b ovr@42=%b pulses=%0d required 1 1 1 2",
                     cap_fs[46], cap_fs[92], cap_ovr[42], novr);
        end
        go_idle();
    endtask

    task automatic test_clamp_update();
        int l1, l2;
        cfg_write(3'd0, 16'd5);
        cfg_write(3'd1, 16'd0);
        cfg_write(3'd2, 16'd7);
        cfg_write(3'd3, 16'd8);
        Enable = 1'b1;
        @(negedge ClkFast);
        fork
            record(81);
            begin
                repeat (10) @(negedge ClkFast);
                cfg_write(3'd0, 16'd9);
            end
        join
        build_frame(5, 0, 7, 8, 0, l1);
        build_frame(9, 0, 7, 8, l1, l2);
        total++;
        if (cap_ch[10] !== 3'd2) begin
            bad++;
            $display("FAIL write_during_ch2: got ChIndex=%0d at write required 2", cap_ch[10]);
        end
        for (int i = 0; i < 80; i++) begin
            total++;
            if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !==
                {exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i], 1'b1}) begin
                bad++;
                $display("FAIL clamp_update cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/1",
                         i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i],
                         exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        int l1;
        Enable = 1'b1;
        @(negedge ClkFast);
        fork
            record(46);
            begin
                repeat (10) @(negedge ClkFast);
                Enable = 1'b0;
            end
        join
        build_frame(9, 0, 7, 8, 0, l1);
        total++;
        if (cap_ch[10] !== 3'd1) begin
            bad++;
            $display("FAIL drop_during_ch1: got ChIndex=%0d at drop required 1", cap_ch[10]);
        end
        for (int i = 0; i < 46; i++) begin
            total++;
            if (i < 40) begin
                if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !==
                    {exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i], 1'b1}) begin
                    bad++;
                    $display("FAIL enable_drop cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/1",
                             i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i],
                             exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i]);
                end
            end else begin
                if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !== 7'b0) begin
                    bad++;
                    $display("FAIL enable_drop_idle cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required all 0",
                             i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int l1;
        Enable = 1'b1;
        @(negedge ClkFast);
        @(negedge ClkFast);
        total++;
        if ({PPMSIG, ChIndex} !== 4'b1000) begin
            bad++;
            $display("FAIL pre_reset_mark: got ppm/ch=%b/%0d required 1/0", PPMSIG, ChIndex);
        end
        Reset = 1'b1;
        #1;
        total++;
        if ({PPMSIG, FrameStart, ChIndex, Busy, FrameOverrun} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset: got ppm/fs/ch/busy/ovr=%b/%b/%0d/%b/%b required all 0",
                     PPMSIG, FrameStart, ChIndex, Busy, FrameOverrun);
        end
        @(negedge ClkFast);
        Reset = 1'b0;
        @(negedge ClkFast);
        record(41);
        build_frame(0, 0, 0, 0, 0, l1);
        for (int i = 0; i < 40; i++) begin
            total++;
            if ({cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i]} !==
                {exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i], 1'b1}) begin
                bad++;
                $display("FAIL zero_widths cyc=%0d: got ppm/ch/fs/ovr/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/1",
                         i, cap_ppm[i], cap_ch[i], cap_fs[i], cap_ovr[i], cap_busy[i],
                         exp_ppm[i], exp_ch[i], exp_fs[i], exp_ovr[i]);
            end
        end
        total++;
        if (cap_fs[40] !== 1'b1) begin
            bad++;
            $display("FAIL zero_widths_period: got fs@40=%b required 1", cap_fs[40]);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overrun();
        test_clamp_update();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
